// File: rtl/x68k_ldr_sink_if.sv
// Loader download handshake and SDRAM word-write port bundle for x68k_ldr_sink.
// ldr_sum exists only when LDR_CHECKSUM_EN is defined.
interface x68k_ldr_sink_if #(
  parameter int RAM_AW = 24
);
  logic              ldr_aen;
  logic [19:0]       ldr_addr;
  logic [7:0]        ldr_wdat;
  logic              ldr_wr;
  logic              ldr_ack;
  logic              ram_req;
  logic [RAM_AW-1:0] ram_waddr;
  logic [15:0]       ram_wdata;
  logic [1:0]        ram_be;
  logic              ram_ack;
  logic              ldr_idle;
`ifdef LDR_CHECKSUM_EN
  logic [15:0]       ldr_sum;
`endif

  modport master (
    output ldr_aen, ldr_addr, ldr_wdat, ldr_wr, ram_ack,
    input  ldr_ack, ram_req, ram_waddr, ram_wdata, ram_be, ldr_idle
`ifdef LDR_CHECKSUM_EN
    , input ldr_sum
`endif
  );

  modport slave (
    input  ldr_aen, ldr_addr, ldr_wdat, ldr_wr, ram_ack,
    output ldr_ack, ram_req, ram_waddr, ram_wdata, ram_be, ldr_idle
`ifdef LDR_CHECKSUM_EN
    , output ldr_sum
`endif
  );
endinterface

// File: rtl/x68k_ldr_sink.sv
// Loader byte sink: packs ldr_wr byte pairs into big-endian SDRAM word writes.
// Optional byte checksum output is enabled by defining LDR_CHECKSUM_EN.
module x68k_ldr_sink #(
  parameter int                RAM_AW     = 24,
  parameter logic [RAM_AW-1:0] BASE_WADDR = 24'h7F0000
) (
  input  logic           clk_sys_i,
  input  logic           reset_i,
  x68k_ldr_sink_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t            state_q;
  logic              pend_v_q;
  logic [18:0]       pend_addr_q;
  logic [7:0]        pend_byte_q;
  logic              ldr_ack_q;
  logic              ram_req_q;
  logic [RAM_AW-1:0] ram_waddr_q;
  logic [15:0]       ram_wdata_q;
  logic [1:0]        ram_be_q;

  logic [18:0]       in_word;
  logic              in_odd;
  logic              flush_go;
  logic              byte_take;

  function automatic logic [RAM_AW-1:0] word_addr(input logic [18:0] wa);
    return BASE_WADDR + RAM_AW'(wa);
  endfunction

  assign in_word  = bus.ldr_addr[19:1];
  assign in_odd   = bus.ldr_addr[0];
  // A pending even byte must go out alone when the next byte cannot pair with it,
  // or when the download window closes with nothing in flight.
  assign flush_go = pend_v_q &
                    ((bus.ldr_wr & ~ldr_ack_q & (~in_odd | (in_word != pend_addr_q))) |
                     (~bus.ldr_wr & ~bus.ldr_aen));
  assign byte_take = ((state_q == ST_IDLE) & ~flush_go & bus.ldr_wr & bus.ldr_aen & ~in_odd) |
                     ((state_q == ST_WRITE) & bus.ram_ack);

  // Handshake FSM with registered ldr_ack and ram_* outputs.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      pend_v_q    <= 1'b0;
      pend_addr_q <= 19'd0;
      pend_byte_q <= 8'h00;
      ldr_ack_q   <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= 16'h0000;
      ram_be_q    <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_go) begin
            state_q     <= ST_FLUSH;
            ram_req_q   <= 1'b1;
            ram_be_q    <= 2'b10;
            ram_wdata_q <= {pend_byte_q, 8'h00};
            ram_waddr_q <= word_addr(pend_addr_q);
          end else if (bus.ldr_wr && bus.ldr_aen && !in_odd) begin
            state_q     <= ST_ACK;
            pend_v_q    <= 1'b1;
            pend_addr_q <= in_word;
            pend_byte_q <= bus.ldr_wdat;
            ldr_ack_q   <= 1'b1;
          end else if (bus.ldr_wr && bus.ldr_aen && in_odd) begin
            // flush_go is clear here, so any pending byte belongs to this word
            state_q     <= ST_WRITE;
            ram_req_q   <= 1'b1;
            ram_be_q    <= pend_v_q ? 2'b11 : 2'b01;
            ram_wdata_q <= {(pend_v_q ? pend_byte_q : 8'h00), bus.ldr_wdat};
            ram_waddr_q <= word_addr(in_word);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (bus.ram_ack) begin
            state_q   <= ST_IDLE;
            ram_req_q <= 1'b0;
            pend_v_q  <= 1'b0;
          end else begin
            state_q <= ST_FLUSH;
          end
        end
        ST_WRITE: begin
          if (bus.ram_ack) begin
            state_q   <= ST_ACK;
            ram_req_q <= 1'b0;
            pend_v_q  <= 1'b0;
            ldr_ack_q <= 1'b1;
          end else begin
            state_q <= ST_WRITE;
          end
        end
        ST_ACK: begin
          if (!bus.ldr_wr) begin
            state_q   <= ST_IDLE;
            ldr_ack_q <= 1'b0;
          end else begin
            state_q <= ST_ACK;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ram_req_q <= 1'b0;
          ldr_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ldr_ack   = ldr_ack_q;
  assign bus.ram_req   = ram_req_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_be    = ram_be_q;
  assign bus.ldr_idle  = (state_q == ST_IDLE) & ~pend_v_q;

`ifdef LDR_CHECKSUM_EN
  logic        aen_q;
  logic [15:0] sum_q;

  // Wrapping byte sum, restarted whenever a new download window opens.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      aen_q <= 1'b0;
      sum_q <= 16'h0000;
    end else begin
      aen_q <= bus.ldr_aen;
      if (bus.ldr_aen && !aen_q) begin
        sum_q <= 16'h0000;
      end else if (byte_take) begin
        sum_q <= sum_q + {8'h00, bus.ldr_wdat};
      end else begin
        sum_q <= sum_q;
      end
    end
  end

  assign bus.ldr_sum = sum_q;
`endif

endmodule
